// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard receiver: synchronizes and filters the raw PS/2 lines,
// deframes 11-bit frames and turns make/break/extended scancode sequences
// into a toggle-strobed key event word.
module ps2_key_encoder #(
  parameter int TIMEOUT_CYC = 1100,
  parameter int FILTER_LEN  = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int FL_W = $clog2(FILTER_LEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // Odd parity check over the data byte plus its parity bit.
  function automatic logic odd_weight(input logic [7:0] data, input logic par);
    return ^{par, data};
  endfunction

  logic [1:0]      clk_sync_r;
  logic [1:0]      data_sync_r;
  logic            filt_clk_r;
  logic            filt_prev_r;
  logic [FL_W-1:0] filt_cnt_r;
  logic [TO_W-1:0] to_cnt_r;
  logic            fall_s;
  logic            timeout_s;
  logic            bit_s;

  state_t          state_r, state_n;
  logic [2:0]      bit_cnt_r, bit_cnt_n;
  logic [7:0]      shift_r, shift_n;
  logic            par_r, par_n;
  logic            byte_ok_s;
  logic            byte_bad_s;
  logic            err_s;

  logic            ext_r;
  logic            rel_r;
  logic [2:0]      skip_r;

  assign bit_s     = data_sync_r[1];
  assign fall_s    = filt_prev_r & ~filt_clk_r;
  assign timeout_s = (state_r != ST_IDLE) && (to_cnt_r == TO_W'(TIMEOUT_CYC));

  // Two-flop synchronizers for the asynchronous PS/2 lines (idle high).
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_r  <= 2'b11;
      data_sync_r <= 2'b11;
    end else begin
      clk_sync_r  <= {clk_sync_r[0], ps2_clk};
      data_sync_r <= {data_sync_r[0], ps2_data};
    end
  end

  // Glitch filter: accept a new clock level only after FILTER_LEN equal samples.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      filt_clk_r  <= 1'b1;
      filt_prev_r <= 1'b1;
      filt_cnt_r  <= '0;
    end else begin
      filt_prev_r <= filt_clk_r;
      if (clk_sync_r[1] == filt_clk_r) begin
        filt_cnt_r <= '0;
      end else if (filt_cnt_r == FL_W'(FILTER_LEN - 1)) begin
        filt_clk_r <= clk_sync_r[1];
        filt_cnt_r <= '0;
      end else begin
        filt_cnt_r <= filt_cnt_r + FL_W'(1);
      end
    end
  end

  // Inter-edge timeout counter; held at zero while idle, cleared on each edge.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_r <= '0;
    end else if ((state_r == ST_IDLE) || fall_s) begin
      to_cnt_r <= '0;
    end else if (to_cnt_r != TO_W'(TIMEOUT_CYC)) begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end else begin
      to_cnt_r <= to_cnt_r;
    end
  end

  // Frame FSM state register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
      par_r     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_r   <= state_n;
      bit_cnt_r <= bit_cnt_n;
      shift_r   <= shift_n;
      par_r     <= par_n;
      frame_err <= err_s;
    end
  end

  // Frame FSM next state; a timeout wins over a coincident clock edge.
  always_comb begin
    state_n    = state_r;
    bit_cnt_n  = bit_cnt_r;
    shift_n    = shift_r;
    par_n      = par_r;
    byte_ok_s  = 1'b0;
    byte_bad_s = 1'b0;
    err_s      = 1'b0;
    if (timeout_s) begin
      state_n   = ST_IDLE;
      bit_cnt_n = 3'd0;
      shift_n   = 8'h00;
      err_s     = 1'b1;
    end else if (fall_s) begin
      case (state_r)
        ST_IDLE: begin
          if (!bit_s) begin
            state_n   = ST_DATA;
            bit_cnt_n = 3'd0;
            shift_n   = 8'h00;
          end else begin
            err_s = 1'b1;
          end
        end
        ST_DATA: begin
          shift_n = {bit_s, shift_r[7:1]};
          if (bit_cnt_r == 3'd7) begin
            state_n   = ST_PARITY;
            bit_cnt_n = 3'd0;
          end else begin
            bit_cnt_n = bit_cnt_r + 3'd1;
          end
        end
        ST_PARITY: begin
          par_n   = bit_s;
          state_n = ST_STOP;
        end
        ST_STOP: begin
          if (bit_s && odd_weight(shift_r, par_r)) begin
            byte_ok_s = 1'b1;
          end else begin
            byte_bad_s = 1'b1;
            err_s      = 1'b1;
          end
          state_n = ST_IDLE;
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // Scancode decoder: prefix flags, pause-sequence skipping, event output.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ps2_key <= 11'h000;
      ext_r   <= 1'b0;
      rel_r   <= 1'b0;
      skip_r  <= 3'd0;
    end else if (byte_ok_s) begin
      if (skip_r != 3'd0) begin
        skip_r <= skip_r - 3'd1;
      end else if (shift_r == 8'hE0) begin
        ext_r <= 1'b1;
      end else if (shift_r == 8'hF0) begin
        rel_r <= 1'b1;
      end else if (shift_r == 8'hE1) begin
        skip_r <= 3'd7;
        ext_r  <= 1'b0;
        rel_r  <= 1'b0;
      end else begin
        ps2_key <= {~ps2_key[10], ~rel_r, ext_r, shift_r};
        ext_r   <= 1'b0;
        rel_r   <= 1'b0;
      end
    end else if (byte_bad_s) begin
      ext_r  <= 1'b0;
      rel_r  <= 1'b0;
      skip_r <= 3'd0;
    end else begin
      ps2_key <= ps2_key;
    end
  end

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Directed bench for ps2_key_encoder: table of PS/2 frames with expected key
// word, error pulse count and toggle count, plus timeout and reset sequences.
module tb_ps2_key_encoder;

  localparam int TO_CYC = 200;
  localparam int HALF   = 20;
  localparam int NVEC   = 24;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err;

  int errors = 0;
  int checks = 0;
  int err_total = 0;
  int tog_total = 0;
  logic prev10 = 1'b0;

  typedef struct {
    logic [7:0]  b;
    logic        par_bad;
    logic        stop_bad;
    logic        glitch;
    logic [10:0] exp_key;
    int          exp_err;
    int          exp_tog;
  } vec_t;

  vec_t vecs [NVEC];

  ps2_key_encoder #(.TIMEOUT_CYC(TO_CYC), .FILTER_LEN(4)) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ps2_key  (ps2_key),
    .frame_err(frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  // Count error pulses and strobe toggles, sampled on the falling edge.
  always @(negedge clk_sys) begin
    if (frame_err) err_total <= err_total + 1;
    if (ps2_key[10] != prev10) tog_total <= tog_total + 1;
    prev10 <= ps2_key[10];
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_bad,
                            input logic stop_bad, input logic glitch, input int nbits);
    logic [10:0] bits;
    bits = {~stop_bad, (~^b) ^ par_bad, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      if (glitch && i == 3) begin
        wait_clk(5);
        ps2_clk = 1'b0;
        wait_clk(1);
        ps2_clk = 1'b1;
        wait_clk(HALF - 6);
      end else begin
        wait_clk(HALF);
      end
      ps2_clk = 1'b0;
      wait_clk(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic run_vec(input int i);
    int e0, t0;
    e0 = err_total;
    t0 = tog_total;
    send_frame(vecs[i].b, vecs[i].par_bad, vecs[i].stop_bad, vecs[i].glitch, 11);
    wait_clk(60);
    check($sformatf("key[%0d]", i), int'(ps2_key), int'(vecs[i].exp_key));
    check($sformatf("err[%0d]", i), err_total - e0, vecs[i].exp_err);
    check($sformatf("tog[%0d]", i), tog_total - t0, vecs[i].exp_tog);
  endtask

  initial begin
    int e0, t0;
    //            byte   pbad  sbad  glit  key       err tog
    vecs[0]  = '{8'h1C, 1'b0, 1'b0, 1'b0, 11'h61C, 0, 1};
    vecs[1]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 11'h61C, 0, 0};
    vecs[2]  = '{8'h1C, 1'b0, 1'b0, 1'b0, 11'h01C, 0, 1};
    vecs[3]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 11'h01C, 0, 0};
    vecs[4]  = '{8'h75, 1'b0, 1'b0, 1'b0, 11'h775, 0, 1};
    vecs[5]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 11'h775, 0, 0};
    vecs[6]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 11'h775, 0, 0};
    vecs[7]  = '{8'h75, 1'b0, 1'b0, 1'b0, 11'h175, 0, 1};
    vecs[8]  = '{8'h29, 1'b1, 1'b0, 1'b0, 11'h175, 1, 0};
    vecs[9]  = '{8'h29, 1'b0, 1'b0, 1'b0, 11'h629, 0, 1};
    vecs[10] = '{8'hE0, 1'b0, 1'b0, 1'b0, 11'h629, 0, 0};
    vecs[11] = '{8'h12, 1'b0, 1'b1, 1'b0, 11'h629, 1, 0};
    vecs[12] = '{8'h12, 1'b0, 1'b0, 1'b0, 11'h212, 0, 1};
    // after the timeout sequence
    vecs[13] = '{8'h16, 1'b0, 1'b0, 1'b0, 11'h616, 0, 1};
    vecs[14] = '{8'hE1, 1'b0, 1'b0, 1'b0, 11'h616, 0, 0};
    vecs[15] = '{8'h14, 1'b0, 1'b0, 1'b0, 11'h616, 0, 0};
    vecs[16] = '{8'h77, 1'b0, 1'b0, 1'b0, 11'h616, 0, 0};
    vecs[17] = '{8'hE1, 1'b0, 1'b0, 1'b0, 11'h616, 0, 0};
    vecs[18] = '{8'hF0, 1'b0, 1'b0, 1'b1, 11'h616, 0, 0};
    vecs[19] = '{8'h14, 1'b0, 1'b0, 1'b0, 11'h616, 0, 0};
    vecs[20] = '{8'hF0, 1'b0, 1'b0, 1'b0, 11'h616, 0, 0};
    vecs[21] = '{8'h77, 1'b0, 1'b0, 1'b1, 11'h616, 0, 0};
    vecs[22] = '{8'h05, 1'b0, 1'b0, 1'b0, 11'h205, 0, 1};
    // after the mid-frame reset sequence
    vecs[23] = '{8'h1C, 1'b0, 1'b0, 1'b0, 11'h61C, 0, 1};

    // Reset state
    wait_clk(5);
    check("reset_key", int'(ps2_key), 0);
    check("reset_err", int'(frame_err), 0);
    reset_n = 1'b1;
    wait_clk(10);
    check("idle_key", int'(ps2_key), 0);

    for (int i = 0; i <= 12; i++) run_vec(i);

    // Timeout: four data bits, then the clock stops
    e0 = err_total;
    t0 = tog_total;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 5);
    wait_clk(TO_CYC + 100);
    check("timeout_err", err_total - e0, 1);
    check("timeout_tog", tog_total - t0, 0);
    check("timeout_key", int'(ps2_key), 11'h212);

    for (int i = 13; i <= 22; i++) run_vec(i);

    // Reset in the middle of a frame
    e0 = err_total;
    send_frame(8'h33, 1'b0, 1'b0, 1'b0, 4);
    wait_clk(5);
    reset_n = 1'b0;
    #1;
    check("midrst_key", int'(ps2_key), 0);
    check("midrst_ferr", int'(frame_err), 0);
    wait_clk(10);
    reset_n = 1'b1;
    wait_clk(TO_CYC + 100);
    check("midrst_errcnt", err_total - e0, 0);
    check("midrst_hold", int'(ps2_key), 0);

    run_vec(23);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_key_encoder.md
PS2_KEY_ENCODER -- requirements
Module: ps2_key_encoder

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1100, max clk_sys cycles allowed between PS/2 clock falling edges inside a frame.
REQ-002 Parameter FILTER_LEN, default 4, consecutive equal clk_sys samples needed to accept a new ps2_clk level.
REQ-003 clk_sys  input  1  system clock; all logic on rising edge; no other clock.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 ps2_clk  input  1  raw PS/2 device clock; asynchronous to clk_sys.
REQ-006 ps2_data  input  1  raw PS/2 device data; asynchronous to clk_sys.
REQ-007 ps2_key  output  11  key event word: [10] toggle strobe, [9] pressed, [8] extended (E0), [7:0] scancode.
REQ-008 frame_err  output  1  one-cycle pulse on a parity, start, stop or timeout error.

Function
REQ-009 ps2_clk and ps2_data SHALL each pass a 2-flop synchronizer before any use.
REQ-010 Synchronized ps2_clk SHALL be glitch-filtered: the filtered level changes only after FILTER_LEN consecutive equal samples.
REQ-011 A bit SHALL be sampled from synchronized ps2_data on the clk_sys cycle the filtered clock falls (1->0).
REQ-012 Frame FSM states: IDLE, DATA, PARITY, STOP.
REQ-013 IDLE: sampled bit 0 -> DATA with bit counter 0; sampled bit 1 -> stay IDLE and pulse frame_err.
REQ-014 DATA: shift bits in LSB first; after the 8th bit -> PARITY.
REQ-015 PARITY: capture bit; data plus parity must have odd weight; -> STOP.
REQ-016 STOP: sampled bit must be 1 and parity good for a valid byte; otherwise pulse frame_err; always -> IDLE.
REQ-017 Timeout counter SHALL reset on each filtered falling edge; outside IDLE, reaching TIMEOUT_CYC SHALL force IDLE, pulse frame_err, and clear the partial byte.
REQ-018 Valid byte 0xE0 SHALL set the ext flag and produce no event.
REQ-019 Valid byte 0xF0 SHALL set the release flag and produce no event; ext is kept.
REQ-020 Valid byte 0xE1 SHALL load a skip counter of 7, produce no event, and clear ext and release.
REQ-021 While the skip counter is nonzero, each valid byte SHALL decrement it and produce no event.
REQ-022 Any other valid byte B SHALL set ps2_key[9:0] = {~release, ext, B}, invert ps2_key[10], then clear ext and release.
REQ-023 The ps2_key update SHALL occur exactly 1 clk_sys cycle after the stop-bit sampling edge; ps2_key[9:0] is stable whenever [10] toggles.
REQ-024 An invalid byte (parity or stop error) SHALL clear ext, release and the skip counter and produce no event.
REQ-025 ps2_key SHALL hold its value between events; at most one toggle per frame.
REQ-026 A filtered falling edge in the same cycle the timeout is reached SHALL be treated as the timeout; the edge is discarded.

Reset
REQ-027 reset_n low SHALL immediately force: FSM IDLE, ps2_key = 0, frame_err = 0, ext/release/skip cleared, timeout and filter counters 0, synchronizers 1.
REQ-028 Reset asserted mid-frame SHALL drop the partial byte with no frame_err pulse.
REQ-029 After reset_n rises, the first event SHALL still toggle ps2_key[10] from 0 to 1.

Verification
REQ-030 Frame 0x1C, parity 0 -> ps2_key = 0x61C ([10]=1, [9]=1, [8]=0) one cycle after the stop edge; frame_err stays 0.
REQ-031 Bytes F0,1C after REQ-030 -> ps2_key = 0x01C (toggle back to 0, released); no event on F0.
REQ-032 Bytes E0,75 then E0,F0,75 -> 0x775, then 0x175.
REQ-033 Frame 0x29 with wrong parity -> frame_err pulse, ps2_key unchanged; next valid 0x29 -> toggle with [9:0] = 0x229.
REQ-034 Stop clocking after 4 data bits for TIMEOUT_CYC cycles -> frame_err pulse, FSM IDLE; next full frame 0x16 decodes correctly.
REQ-035 Sequence E1,14,77,E1,F0,14,F0,77 then 0x05 -> no event for the first 8 bytes, one event 0x?05 with [9:8]=2'b10; 1-cycle ps2_clk glitch during the stream -> no extra bit sampled.
